// File: rtl/noc_channel_arbiter.sv
// Packet-atomic round-robin arbiter: merges CHANNELS flit streams onto one link
// through a single registered output stage tagged with the source channel.
module noc_channel_arbiter #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]                 in_last,
  input  logic [CHANNELS-1:0]                 in_valid,
  output logic [CHANNELS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]               out_flit,
  output logic                                out_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHW-1:0]                      out_channel,
  output logic                                busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state;
  logic [CHW-1:0] prio;
  logic [CHW-1:0] cur;
  logic [CHW-1:0] sel;
  logic [CHW-1:0] grant;
  logic [CHW-1:0] prio_next;
  logic [CHW:0]   sum;
  logic           found;
  logic           load;
  logic           xfer;

  assign load  = !out_valid || out_ready;
  assign busy  = (state == LOCKED);
  assign grant = (state == LOCKED) ? cur : sel;
  assign xfer  = |(in_ready & in_valid);

  // Rotating search from prio; the extra sum bit lets the wrap work for any CHANNELS.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum = {1'b0, prio} + (CHW+1)'(i);
      if (sum >= (CHW+1)'(CHANNELS)) sum = sum - (CHW+1)'(CHANNELS);
      if (!found && in_valid[sum[CHW-1:0]]) begin
        sel   = sum[CHW-1:0];
        found = 1'b1;
      end
    end
  end

  assign prio_next = (sel == CHW'(CHANNELS - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    in_ready = '0;
    if (!rst && load) begin
      if (state == LOCKED) in_ready[cur] = 1'b1;
      else if (found)      in_ready[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= '0;
      cur         <= '0;
      out_valid   <= 1'b0;
      out_flit    <= '0;
      out_last    <= 1'b0;
      out_channel <= '0;
    end else begin
      if (xfer) begin
        out_valid   <= 1'b1;
        out_flit    <= in_flit[grant];
        out_last    <= in_last[grant];
        out_channel <= grant;
        if (state == IDLE) begin
          prio <= prio_next;
          if (!in_last[sel]) begin
            state <= LOCKED;
            cur   <= sel;
          end
        end else if (in_last[cur]) begin
          state <= IDLE;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_channel_arbiter.sv
// Bench for noc_channel_arbiter: directed scenarios on 2- and 4-channel instances
// plus a randomized stress run against a behavioural arbitration model.
module tb_noc_channel_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][31:0] f2;
  logic [1:0]       l2, v2, r2;
  logic [31:0]      of2;
  logic             ol2, ov2, ordy2, busy2;
  logic [0:0]       oc2;

  logic [3:0][31:0] f4;
  logic [3:0]       l4, v4, r4;
  logic [31:0]      of4;
  logic             ol4, ov4, ordy4, busy4;
  logic [1:0]       oc4;

  int n_checks = 0;
  int n_fail   = 0;

  noc_channel_arbiter #(.FLIT_WIDTH(32), .CHANNELS(2)) u2 (
    .clk(clk), .rst(rst), .in_flit(f2), .in_last(l2), .in_valid(v2), .in_ready(r2),
    .out_flit(of2), .out_last(ol2), .out_valid(ov2), .out_ready(ordy2),
    .out_channel(oc2), .busy(busy2)
  );

  noc_channel_arbiter #(.FLIT_WIDTH(32), .CHANNELS(4)) u4 (
    .clk(clk), .rst(rst), .in_flit(f4), .in_last(l4), .in_valid(v4), .in_ready(r4),
    .out_flit(of4), .out_last(ol4), .out_valid(ov4), .out_ready(ordy4),
    .out_channel(oc4), .busy(busy4)
  );

  task automatic clear_inputs;
    f2 = '0; l2 = '0; v2 = '0; ordy2 = 1'b0;
    f4 = '0; l4 = '0; v4 = '0; ordy4 = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    v2 = 2'b11; l2 = 2'b11; ordy2 = 1'b1;
    v4 = 4'b1111; l4 = 4'b1111; ordy4 = 1'b1;
    #1;
    n_checks++; if (r2 !== 2'b00) begin n_fail++; $display("FAIL reset_in_ready2 got=%b exp=00", r2); end
    n_checks++; if (r4 !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready4 got=%b exp=0000", r4); end
    @(posedge clk); #1;
    n_checks++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", ov2); end
    n_checks++; if (of2 !== 32'h0) begin n_fail++; $display("FAIL reset_out_flit got=%h exp=0", of2); end
    n_checks++; if (ol2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", ol2); end
    n_checks++; if (oc2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_channel got=%b exp=0", oc2); end
    n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy2); end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid4 got=%b exp=0", ov4); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_round_robin;
    logic [1:0] e;
    do_reset();
    ordy2 = 1'b1; v2 = 2'b11; l2 = 2'b11;
    f2[0] = 32'hA000_0000; f2[1] = 32'hB000_0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (r2 !== e) begin n_fail++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, r2, e); end
      @(posedge clk); #1;
      n_checks++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL rr_out_valid[%0d] got=%b exp=1", k, ov2); end
      n_checks++; if (oc2 !== 1'(k % 2)) begin n_fail++; $display("FAIL rr_out_channel[%0d] got=%0d exp=%0d", k, oc2, k % 2); end
      n_checks++; if (of2 !== ((k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000)) begin
        n_fail++; $display("FAIL rr_out_flit[%0d] got=%h", k, of2);
      end
    end
    clear_inputs();
  endtask

  task automatic test_packet_lock;
    do_reset();
    ordy2 = 1'b1; v2 = 2'b11; l2[1] = 1'b1; f2[1] = 32'hB0;
    for (int i = 0; i < 3; i++) begin
      f2[0] = 32'hA0 + 32'(i);
      l2[0] = (i == 2);
      #1;
      n_checks++; if (r2 !== 2'b01) begin n_fail++; $display("FAIL lock_in_ready[%0d] got=%b exp=01", i, r2); end
      @(posedge clk); #1;
      n_checks++; if (of2 !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL lock_out_flit[%0d] got=%h exp=%h", i, of2, 32'hA0 + 32'(i)); end
      n_checks++; if (oc2 !== 1'b0) begin n_fail++; $display("FAIL lock_out_channel[%0d] got=%0d exp=0", i, oc2); end
      n_checks++; if (ol2 !== (i == 2)) begin n_fail++; $display("FAIL lock_out_last[%0d] got=%b", i, ol2); end
      n_checks++; if (busy2 !== (i < 2)) begin n_fail++; $display("FAIL lock_busy[%0d] got=%b exp=%b", i, busy2, (i < 2)); end
    end
    v2 = 2'b10;
    #1;
    n_checks++; if (r2 !== 2'b10) begin n_fail++; $display("FAIL lock_next_in_ready got=%b exp=10", r2); end
    @(posedge clk); #1;
    n_checks++; if (oc2 !== 1'b1 || of2 !== 32'hB0) begin
      n_fail++; $display("FAIL lock_next_out got ch=%0d flit=%h exp ch=1 flit=b0", oc2, of2);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure;
    do_reset();
    ordy2 = 1'b0; v2 = 2'b01; l2 = 2'b01; f2[0] = 32'hC0;
    #1;
    n_checks++; if (r2 !== 2'b01) begin n_fail++; $display("FAIL bp_first_in_ready got=%b exp=01", r2); end
    @(posedge clk); #1;
    f2[0] = 32'hC1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (r2 !== 2'b00) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=00", i, r2); end
      @(posedge clk); #1;
      n_checks++; if (ov2 !== 1'b1 || of2 !== 32'hC0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got valid=%b flit=%h exp valid=1 flit=c0", i, ov2, of2);
      end
    end
    ordy2 = 1'b1;
    #1;
    n_checks++; if (r2 !== 2'b01) begin n_fail++; $display("FAIL bp_reload_in_ready got=%b exp=01", r2); end
    @(posedge clk); #1;
    n_checks++; if (ov2 !== 1'b1 || of2 !== 32'hC1) begin
      n_fail++; $display("FAIL bp_drain_load got valid=%b flit=%h exp valid=1 flit=c1", ov2, of2);
    end
    v2 = 2'b00;
    @(posedge clk); #1;
    n_checks++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL bp_drain_empty got=%b exp=0", ov2); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet;
    do_reset();
    ordy2 = 1'b1; v2 = 2'b01; l2 = 2'b00;
    for (int i = 0; i < 2; i++) begin
      f2[0] = 32'hD0 + 32'(i);
      @(posedge clk); #1;
      n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL rmp_busy[%0d] got=%b exp=1", i, busy2); end
    end
    f2[0] = 32'hD2;
    rst = 1'b1;
    #1;
    n_checks++; if (r2 !== 2'b00) begin n_fail++; $display("FAIL rmp_in_ready_rst got=%b exp=00", r2); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (ov2 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL rmp_after_rst got valid=%b busy=%b exp 0 0", ov2, busy2);
    end
    v2 = 2'b11; l2 = 2'b11; f2[0] = 32'hE0; f2[1] = 32'hE1;
    #1;
    n_checks++; if (r2 !== 2'b01) begin n_fail++; $display("FAIL rmp_first_grant got=%b exp=01", r2); end
    @(posedge clk); #1;
    n_checks++; if (oc2 !== 1'b0 || of2 !== 32'hE0) begin
      n_fail++; $display("FAIL rmp_first_out got ch=%0d flit=%h exp ch=0 flit=e0", oc2, of2);
    end
    clear_inputs();
  endtask

  task automatic test_four_channel_rr;
    logic [3:0] e;
    do_reset();
    ordy4 = 1'b1; v4 = 4'b1010; l4 = 4'b1111;
    for (int c = 0; c < 4; c++) f4[c] = 32'hF0 + 32'(c);
    for (int k = 0; k < 4; k++) begin
      #1;
      e = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      n_checks++; if (r4 !== e) begin n_fail++; $display("FAIL rr4_in_ready[%0d] got=%b exp=%b", k, r4, e); end
      @(posedge clk); #1;
      n_checks++; if (oc4 !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin
        n_fail++; $display("FAIL rr4_out_channel[%0d] got=%0d exp=%0d", k, oc4, (k % 2 == 0) ? 1 : 3);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random_stress;
    int unsigned seq[4];
    int unsigned rem[4];
    int unsigned exp_seq[4];
    bit          m_locked, m_ov, m_ol, load;
    int          m_cur, m_prio, m_oc, sel, c, t_ch, owner;
    logic [31:0] m_of;
    logic [3:0]  e;
    do_reset();
    m_locked = 0; m_ov = 0; m_ol = 0; m_of = '0; m_oc = 0; m_cur = 0; m_prio = 0; owner = -1;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0; exp_seq[i] = 0; rem[i] = $urandom_range(1, 4);
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int ch = 0; ch < 4; ch++) begin
        v4[ch] = (cyc < 9980) && ($urandom_range(0, 9) < 7);
        f4[ch] = {8'(ch), 24'(seq[ch])};
        l4[ch] = (rem[ch] == 1);
      end
      ordy4 = (cyc >= 9980) || ($urandom_range(0, 3) != 0);
      #1;
      load = !m_ov || ordy4;
      e = '0; sel = -1;
      if (m_locked) begin
        if (load) e[m_cur] = 1'b1;
      end else if (load) begin
        for (int k = 0; k < 4; k++) begin
          c = (m_prio + k) % 4;
          if (sel < 0 && v4[c]) sel = c;
        end
        if (sel >= 0) e[sel] = 1'b1;
      end
      n_checks++; if (r4 !== e) begin n_fail++; $display("FAIL stress_in_ready cyc=%0d got=%b exp=%b", cyc, r4, e); end
      n_checks++; if (ov4 !== m_ov) begin n_fail++; $display("FAIL stress_out_valid cyc=%0d got=%b exp=%b", cyc, ov4, m_ov); end
      n_checks++; if (busy4 !== m_locked) begin n_fail++; $display("FAIL stress_busy cyc=%0d got=%b exp=%b", cyc, busy4, m_locked); end
      if (m_ov) begin
        n_checks++; if (of4 !== m_of || ol4 !== m_ol || oc4 !== 2'(m_oc)) begin
          n_fail++; $display("FAIL stress_out cyc=%0d got %h/%b/%0d exp %h/%b/%0d", cyc, of4, ol4, oc4, m_of, m_ol, m_oc);
        end
      end
      if (ov4 && ordy4) begin
        c = int'(oc4);
        n_checks++; if (of4 !== {8'(c), 24'(exp_seq[c])}) begin
          n_fail++; $display("FAIL stress_order cyc=%0d ch=%0d got=%h exp_seq=%0d", cyc, c, of4, exp_seq[c]);
        end
        if (owner >= 0) begin
          n_checks++; if (c != owner) begin n_fail++; $display("FAIL stress_interleave cyc=%0d got ch=%0d exp ch=%0d", cyc, c, owner); end
        end
        exp_seq[c]++;
        owner = ol4 ? -1 : c;
      end
      t_ch = -1;
      for (int k = 0; k < 4; k++) if (e[k] && v4[k]) t_ch = k;
      if (t_ch >= 0) begin
        m_ov = 1; m_of = f4[t_ch]; m_ol = l4[t_ch]; m_oc = t_ch;
        if (!m_locked) begin
          m_prio = (t_ch + 1) % 4; m_locked = !l4[t_ch]; m_cur = t_ch;
        end else if (l4[t_ch]) begin
          m_locked = 0;
        end
      end else if (ordy4) begin
        m_ov = 0;
      end
      for (int ch = 0; ch < 4; ch++) begin
        if (r4[ch] && v4[ch]) begin
          seq[ch]++;
          if (rem[ch] == 1) rem[ch] = $urandom_range(1, 4);
          else rem[ch]--;
        end
      end
      @(posedge clk); #1;
    end
    for (int ch = 0; ch < 4; ch++) begin
      n_checks++; if (exp_seq[ch] != seq[ch]) begin
        n_fail++; $display("FAIL stress_count ch=%0d got=%0d exp=%0d", ch, exp_seq[ch], seq[ch]);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_four_channel_rr();
    test_random_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
